// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, FSM state type and command struct shared by the ALU issue stage
package alu_pkg;

    localparam logic [1:0] ALU_OP_SRA = 2'b00;
    localparam logic [1:0] ALU_OP_SRL = 2'b01;
    localparam logic [1:0] ALU_OP_SUB = 2'b10;
    localparam logic [1:0] ALU_OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] c;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO of alu_cmd_t entries with full/empty from the registered count
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  alu_cmd_t data_i,
    input  logic     pop_i,
    output alu_cmd_t data_o,
    output logic     full_o,
    output logic     empty_o
);
    localparam int AW = $clog2(DEPTH);

    alu_cmd_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // pointers wrap naturally at DEPTH; count tracks push minus pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // storage needs no reset: an empty count makes stale entries unreachable
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU commands and issues them one at a time; optional result counter under ALU_ISSUE_CNT_EN
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_c,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_c,
    output logic [1:0] alu_op,
    input  logic [3:0] alu_ans,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic [1:0] res_op
`ifdef ALU_ISSUE_CNT_EN
    ,
    output logic [7:0] res_cnt
`endif
);
    state_e     state_q;
    state_e     state_d;
    alu_cmd_t   alu_q;
    alu_cmd_t   head;
    logic [3:0] res_data_q;
    logic [1:0] res_op_q;
    logic       full;
    logic       empty;
    logic       pop;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (cmd_valid),
        .data_i ('{op: cmd_op, a: cmd_a, b: cmd_b, c: cmd_c}),
        .pop_i  (pop),
        .data_o (head),
        .full_o (full),
        .empty_o(empty)
    );

    assign cmd_ready = !full;
    assign res_valid = state_q == ST_RESP;
    assign alu_a     = alu_q.a;
    assign alu_b     = alu_q.b;
    assign alu_c     = alu_q.c;
    assign alu_op    = alu_q.op;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;

    // issue sequencing: pop on IDLE or on result handshake whenever a command waits
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pop     = !empty;
                state_d = empty ? ST_IDLE : ST_EXEC;
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                pop     = res_ready && !empty;
                state_d = !res_ready ? ST_RESP : (empty ? ST_IDLE : ST_EXEC);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state, ALU operand registers (load on pop) and result capture in EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            alu_q      <= '0;
            res_data_q <= '0;
            res_op_q   <= '0;
        end else begin
            state_q <= state_d;
            if (pop) alu_q <= head;
            if (state_q == ST_EXEC) begin
                res_data_q <= alu_ans;
                res_op_q   <= alu_q.op;
            end
        end
    end

`ifdef ALU_ISSUE_CNT_EN
    logic [7:0] cnt_q;

    // saturating count of result handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (res_valid && res_ready && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end

    assign res_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with a behavioural 4-bit ALU on the alu_* lines
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic [1:0] cmd_c = '0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_c;
    logic [1:0] alu_op;
    logic [3:0] alu_ans;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_data;
    logic [1:0] res_op;
`ifdef ALU_ISSUE_CNT_EN
    logic [7:0] res_cnt;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = !clk;

    always_comb begin
        case (alu_op)
            2'b00:   alu_ans = 4'($signed(alu_a) >>> alu_c);
            2'b01:   alu_ans = alu_a >> alu_c;
            2'b10:   alu_ans = alu_a - alu_b;
            default: alu_ans = alu_a + alu_b;
        endcase
    end

    alu_issue_ctrl #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .cmd_c    (cmd_c),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_c    (alu_c),
        .alu_op   (alu_op),
        .alu_ans  (alu_ans),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_op   (res_op)
`ifdef ALU_ISSUE_CNT_EN
        ,
        .res_cnt  (res_cnt)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_c = c;
    endtask

    initial begin
        // reset values
        tick();
        tick();
        check("rst_cmd_ready", 8'(cmd_ready), 8'd1);
        check("rst_res_valid", 8'(res_valid), 8'd0);
        check("rst_alu", {alu_a, alu_op, alu_c}, 8'd0);
        check("rst_alu_b", 8'(alu_b), 8'd0);
        check("rst_res", {res_data, 2'b00, res_op}, 8'd0);
`ifdef ALU_ISSUE_CNT_EN
        check("rst_cnt", res_cnt, 8'd0);
`endif
        rst_n = 1'b1;
        tick();

        // SRA 1000 >>> 2
        res_ready = 1'b1;
        set_cmd(2'b00, 4'b1000, 4'd0, 2'd2);
        tick();
        cmd_valid = 1'b0;
        check("sra_wait0", 8'(res_valid), 8'd0);
        tick();
        check("sra_wait1", 8'(res_valid), 8'd0);
        check("sra_alu_a", 8'(alu_a), 8'h8);
        check("sra_alu_c", 8'(alu_c), 8'd2);
        tick();
        check("sra_valid", 8'(res_valid), 8'd1);
        check("sra_data", 8'(res_data), 8'hE);
        check("sra_op", 8'(res_op), 8'd0);
        tick();
        check("sra_done", 8'(res_valid), 8'd0);
`ifdef ALU_ISSUE_CNT_EN
        check("cnt_1", res_cnt, 8'd1);
`endif

        // SRL then SUB, back to back
        set_cmd(2'b01, 4'b1000, 4'd0, 2'd2);
        tick();
        set_cmd(2'b10, 4'd3, 4'd5, 2'd0);
        tick();
        cmd_valid = 1'b0;
        check("srl_wait", 8'(res_valid), 8'd0);
        tick();
        check("srl_valid", 8'(res_valid), 8'd1);
        check("srl_data", 8'(res_data), 8'h2);
        check("srl_op", 8'(res_op), 8'd1);
        tick();
        check("sub_wait", 8'(res_valid), 8'd0);
        check("sub_alu_b", 8'(alu_b), 8'd5);
        tick();
        check("sub_valid", 8'(res_valid), 8'd1);
        check("sub_data", 8'(res_data), 8'hE);
        check("sub_op", 8'(res_op), 8'd2);
        tick();
        check("sub_done", 8'(res_valid), 8'd0);
`ifdef ALU_ISSUE_CNT_EN
        check("cnt_3", res_cnt, 8'd3);
`endif

        // ADD wraps mod 16
        set_cmd(2'b11, 4'd9, 4'd8, 2'd0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("add_valid", 8'(res_valid), 8'd1);
        check("add_data", 8'(res_data), 8'h1);
        check("add_op", 8'(res_op), 8'd3);
        tick();

        // backpressure: five accepts fill FIFO plus one in flight
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            check("fill_ready", 8'(cmd_ready), 8'd1);
            set_cmd(2'b11, 4'(i), 4'd1, 2'd0);
            tick();
        end
        cmd_valid = 1'b0;
        check("full_ready", 8'(cmd_ready), 8'd0);
        check("full_valid", 8'(res_valid), 8'd1);
        check("full_data", 8'(res_data), 8'h2);
        tick();
        tick();
        check("hold_ready", 8'(cmd_ready), 8'd0);
        check("hold_data", 8'(res_data), 8'h2);
        check("hold_valid", 8'(res_valid), 8'd1);
        res_ready = 1'b1;
        tick();
        check("drain_ready", 8'(cmd_ready), 8'd1);
        for (int i = 3; i <= 6; i++) begin
            check("drain_gap", 8'(res_valid), 8'd0);
            tick();
            check("drain_valid", 8'(res_valid), 8'd1);
            check("drain_data", 8'(res_data), 8'(i));
            tick();
        end
        check("drain_idle", 8'(res_valid), 8'd0);
`ifdef ALU_ISSUE_CNT_EN
        check("cnt_9", res_cnt, 8'd9);
`endif

        // reset while in RESP with three queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_cmd(2'b11, 4'd7, 4'd7, 2'd3);
            tick();
        end
        cmd_valid = 1'b0;
        check("pre_rst_valid", 8'(res_valid), 8'd1);
        check("pre_rst_data", 8'(res_data), 8'hE);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 8'(res_valid), 8'd0);
        check("mid_rst_ready", 8'(cmd_ready), 8'd1);
        check("mid_rst_alu", {alu_a, alu_op, alu_c}, 8'd0);
        check("mid_rst_res", {res_data, 2'b00, res_op}, 8'd0);
`ifdef ALU_ISSUE_CNT_EN
        check("mid_rst_cnt", res_cnt, 8'd0);
`endif
        tick();
        rst_n = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_valid", 8'(res_valid), 8'd0);
        end

`ifdef ALU_ISSUE_CNT_EN
        // saturation: continuous traffic gives roughly one handshake per two cycles
        set_cmd(2'b11, 4'd1, 4'd1, 2'd0);
        for (int i = 0; i < 620; i++) tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("cnt_sat", res_cnt, 8'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
